bitonic_sort_ctrl: RTL and testbench

- Batch scheduler that sits in front of `bitonic_sort`.
- Collects a stream of key/value items into a batch of 2*V entries and launches the batch into the sorting network.
- Waits out the fixed network latency, captures the sorted result, and streams the valid entries back out with a valid/ready handshake.
- One batch in flight at a time; partial batches are closed by `flush` and padded with invalid entries.

---
 rtl/bitonic_pkg.sv | 35 +++
 rtl/bitonic_drain_skip.sv | 40 ++++
 rtl/bitonic_sort_ctrl.sv | 148 ++++++++++++++
 tb/tb_bitonic_sort_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitonic_pkg.sv
// Shared types and element helpers for the bitonic sort batch controller.
// Element layout: {vld, key, value}; padding entries are all-zero.
package bitonic_pkg;

    localparam int unsigned V_DEF       = 8;
    localparam int unsigned KEY_W_DEF   = 32;
    localparam int unsigned VALUE_W_DEF = 32;

    localparam int unsigned ELEM_W = KEY_W_DEF + VALUE_W_DEF + 1;
    localparam int unsigned BATCH  = 2 * V_DEF;
    localparam int unsigned IDX_W  = $clog2(BATCH) + 1;

    // Helpers take a zero-extended element so any instance width up to this bound works.
    localparam int unsigned ELEM_MAX_W = 256;

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        DRAIN
    } ctrl_state_e;

    function automatic logic elem_vld(input logic [ELEM_MAX_W-1:0] elem,
                                      input int unsigned payload_w);
        return elem[payload_w];
    endfunction

    function automatic logic [ELEM_MAX_W-1:0] elem_payload(input logic [ELEM_MAX_W-1:0] elem,
                                                           input int unsigned payload_w);
        logic [ELEM_MAX_W-1:0] mask;
        mask = '1;
        mask = ~(mask << payload_w);
        return elem & mask;
    endfunction

endpackage

// File: rtl/bitonic_drain_skip.sv
// Presents the result entry at drain_idx and decides whether to advance:
// invalid entries are skipped one per cycle, valid ones advance on handshake.
module bitonic_drain_skip
    import bitonic_pkg::*;
#(
    parameter int unsigned N_BATCH = BATCH,
    parameter int unsigned PAY_W   = ELEM_W - 1,
    parameter int unsigned CNT_W   = IDX_W
) (
    input  logic             active,
    input  logic [PAY_W:0]   res [N_BATCH],
    input  logic [CNT_W-1:0] drain_idx,
    input  logic [CNT_W-1:0] remaining,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [PAY_W-1:0] out_data,
    output logic             out_last,
    output logic             advance,
    output logic             handshake,
    output logic             done
);

    logic [PAY_W:0] cur;
    logic           cur_vld;

    always_comb begin
        cur = '0;
        if (drain_idx < CNT_W'(N_BATCH)) begin
            cur = res[drain_idx[CNT_W-2:0]];
        end
        cur_vld   = elem_vld(ELEM_MAX_W'(cur), PAY_W);
        out_valid = active && cur_vld;
        out_data  = active ? PAY_W'(elem_payload(ELEM_MAX_W'(cur), PAY_W)) : '0;
        out_last  = out_valid && (remaining == CNT_W'(1));
        handshake = out_valid && out_ready;
        advance   = active && (!cur_vld || handshake);
        done      = handshake && (remaining == CNT_W'(1));
    end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Batch scheduler in front of bitonic_sort: fills 2*V entries, launches them,
// waits SORT_LAT cycles, captures the result and streams valid entries out.
module bitonic_sort_ctrl
    import bitonic_pkg::*;
#(
    parameter int unsigned V           = V_DEF,
    parameter int unsigned key_width   = KEY_W_DEF,
    parameter int unsigned value_width = VALUE_W_DEF,
    parameter int unsigned SORT_LAT    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [key_width+value_width-1:0] in_data,
    input  logic                             flush,
    output logic [key_width+value_width:0]   sort_in_data [2*V],
    output logic                             sort_start,
    input  logic [key_width+value_width:0]   sort_out_data [2*V],
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [key_width+value_width-1:0] out_data,
    output logic                             out_last,
    output logic                             busy
);

    localparam int unsigned PAY_W   = key_width + value_width;
    localparam int unsigned N_BATCH = 2 * V;
    localparam int unsigned CNT_W   = $clog2(N_BATCH) + 1;
    localparam int unsigned WAIT_W  = $clog2(SORT_LAT + 1);

    ctrl_state_e      state;
    ctrl_state_e      state_nxt;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] drain_idx;
    logic [CNT_W-1:0] remaining;
    logic [WAIT_W-1:0] wait_cnt;
    logic [PAY_W:0]   batch_buf [N_BATCH];
    logic [PAY_W:0]   res [N_BATCH];

    logic accept;
    logic batch_full;
    logic close_batch;
    logic wait_done;
    logic drain_active;
    logic drain_advance;
    logic drain_handshake;
    logic drain_done;

    assign accept       = (state == FILL) && in_valid && in_ready;
    assign batch_full   = accept && (fill_cnt == CNT_W'(N_BATCH - 1));
    // An empty-batch flush is ignored; a flush alongside an accept closes after it.
    assign close_batch  = (state == FILL) &&
                          (batch_full || (flush && (accept || (fill_cnt != '0))));
    assign wait_done    = (state == WAIT) && (wait_cnt == WAIT_W'(SORT_LAT));
    assign drain_active = (state == DRAIN);
    assign sort_in_data = batch_buf;

    bitonic_drain_skip #(
        .N_BATCH (N_BATCH),
        .PAY_W   (PAY_W),
        .CNT_W   (CNT_W)
    ) u_drain (
        .active    (drain_active),
        .res       (res),
        .drain_idx (drain_idx),
        .remaining (remaining),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .advance   (drain_advance),
        .handshake (drain_handshake),
        .done      (drain_done)
    );

    always_comb begin
        state_nxt  = state;
        sort_start = 1'b0;
        busy       = 1'b0;
        case (state)
            FILL: begin
                if (close_batch) state_nxt = WAIT;
            end
            WAIT: begin
                busy       = 1'b1;
                sort_start = (wait_cnt == '0);
                if (wait_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_done) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            fill_cnt  <= '0;
            wait_cnt  <= '0;
            drain_idx <= '0;
            remaining <= '0;
            in_ready  <= 1'b0;
            for (int unsigned i = 0; i < N_BATCH; i++) begin
                batch_buf[i] <= '0;
                res[i]       <= '0;
            end
        end else begin
            state <= state_nxt;
            // Registered so in_ready stays low through reset and drops right after a batch closes.
            in_ready <= (state_nxt == FILL);
            case (state)
                FILL: begin
                    if (accept) begin
                        batch_buf[fill_cnt[CNT_W-2:0]] <= {1'b1, in_data};
                        fill_cnt <= fill_cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        wait_cnt  <= '0;
                        remaining <= fill_cnt;
                        drain_idx <= '0;
                        for (int unsigned i = 0; i < N_BATCH; i++) begin
                            res[i] <= sort_out_data[i];
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_advance) drain_idx <= drain_idx + CNT_W'(1);
                    if (drain_handshake) remaining <= remaining - CNT_W'(1);
                    if (drain_done) begin
                        fill_cnt <= '0;
                        for (int unsigned i = 0; i < N_BATCH; i++) begin
                            batch_buf[i] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed and randomized checks of bitonic_sort_ctrl against an item-level model:
// each batch must come back as its accepted items in ascending key order.
module tb_bitonic_sort_ctrl;

    localparam int V  = 8;
    localparam int KW = 32;
    localparam int VW = 32;
    localparam int L  = 4;
    localparam int NB = 2 * V;
    localparam int PW = KW + VW;
    localparam int CW = PW + 1;

    typedef logic [PW:0] elem_t;
    typedef elem_t batch_t [NB];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready;
    logic          sort_start;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic [PW-1:0] out_data;
    elem_t         sort_in_data [NB];
    elem_t         sort_out_data [NB];

    always #5 clk = ~clk;

    bitonic_sort_ctrl #(
        .V           (V),
        .key_width   (KW),
        .value_width (VW),
        .SORT_LAT    (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .flush         (flush),
        .sort_in_data  (sort_in_data),
        .sort_start    (sort_start),
        .sort_out_data (sort_out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy)
    );

    // Stand-in sorting network: invalid entries first, then valid ones by ascending key, L cycles late.
    batch_t sorted_now;
    batch_t pipe [L];

    always_comb begin : sorter_stub
        batch_t t;
        elem_t  tmp;
        tmp = '0;
        t   = sort_in_data;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < NB - 1 - i; j++) begin
                if (t[j][PW:VW] > t[j+1][PW:VW]) begin
                    tmp    = t[j];
                    t[j]   = t[j+1];
                    t[j+1] = tmp;
                end
            end
        end
        sorted_now = t;
    end

    always_ff @(posedge clk) begin
        pipe[0] <= sorted_now;
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    always_comb sort_out_data = pipe[L-1];

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            last_acc_cyc = 0;
    int            first_ov_cyc = -1;
    int            n_start = 0;
    bit            last_seen = 1'b0;
    bit            stalled = 1'b0;
    logic [PW-1:0] stall_data = '0;
    logic [PW-1:0] acc_q [$];
    logic [PW-1:0] exp_q [$];
    logic [PW:0]   out_q [$];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (stalled) begin
            check("stall_valid", CW'(out_valid), CW'(1));
            check("stall_data", CW'(out_data), CW'(stall_data));
        end
        if (sort_start) n_start++;
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (in_valid && in_ready) begin
            acc_q.push_back(in_data);
            last_acc_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            out_q.push_back({out_last, out_data});
            if (out_last) last_seen = 1'b1;
        end
        stalled    = out_valid && !out_ready;
        stall_data = out_data;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rnd_item(input int idx);
        logic [KW-1:0] k;
        k = ($urandom() & 32'hFFFF_FFE0) | KW'(idx);
        return {k, VW'($urandom())};
    endfunction

    task automatic push_item(input logic [PW-1:0] d, input bit fl);
        int sz;
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        for (int t = 0; t < 50 && !got; t++) begin
            sz = acc_q.size();
            tick();
            if (acc_q.size() != sz) got = 1'b1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        if (!got) check("push_timeout", CW'(got), CW'(1));
    endtask

    task automatic wait_last(input int budget);
        for (int t = 0; t < budget && !last_seen; t++) tick();
        if (!last_seen) check("drain_timeout", CW'(last_seen), CW'(1));
    endtask

    task automatic check_batch(input string tag);
        logic [PW-1:0] tmp;
        int n;
        exp_q = acc_q;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            for (int j = i + 1; j < n; j++) begin
                if (exp_q[j][PW-1:VW] < exp_q[i][PW-1:VW]) begin
                    tmp      = exp_q[i];
                    exp_q[i] = exp_q[j];
                    exp_q[j] = tmp;
                end
            end
        end
        check({tag, "_count"}, CW'(out_q.size()), CW'(n));
        for (int i = 0; i < n && i < int'(out_q.size()); i++) begin
            check({tag, "_data"}, CW'(out_q[i][PW-1:0]), CW'(exp_q[i]));
            check({tag, "_last"}, CW'(out_q[i][PW]), CW'(i == n - 1));
        end
        acc_q.delete();
        out_q.delete();
        last_seen = 1'b0;
    endtask

    task automatic reset_mid_cycle(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_in_ready"}, CW'(in_ready), CW'(0));
        check({tag, "_out_valid"}, CW'(out_valid), CW'(0));
        check({tag, "_out_last"}, CW'(out_last), CW'(0));
        check({tag, "_out_data"}, CW'(out_data), CW'(0));
        check({tag, "_busy"}, CW'(busy), CW'(0));
        check({tag, "_sort_start"}, CW'(sort_start), CW'(0));
        check({tag, "_sort_in0"}, CW'(sort_in_data[0]), CW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        acc_q.delete();
        out_q.delete();
        last_seen = 1'b0;
        stalled   = 1'b0;
        out_ready = 1'b1;
        check({tag, "_in_ready_back"}, CW'(in_ready), CW'(1));
        for (int t = 0; t < L + 4; t++) begin
            tick();
            check({tag, "_idle"}, CW'(out_valid), CW'(0));
        end
        push_item(rnd_item(1), 1'b0);
        push_item(rnd_item(0), 1'b1);
        wait_last(60);
        check_batch({tag, "_after"});
    endtask

    initial begin
        logic [KW-1:0] keys5 [5];
        int            pat [4];
        keys5 = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
        pat   = '{1, 0, 0, 1};

        // Reset values
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", CW'(in_ready), CW'(0));
        check("rst_out_valid", CW'(out_valid), CW'(0));
        check("rst_out_last", CW'(out_last), CW'(0));
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_sort_start", CW'(sort_start), CW'(0));
        check("rst_sort_in_first", CW'(sort_in_data[0]), CW'(0));
        check("rst_sort_in_last", CW'(sort_in_data[NB-1]), CW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", CW'(in_ready), CW'(1));

        // Full batch, keys 15..0
        n_start = 0;
        first_ov_cyc = -1;
        for (int i = 0; i < NB; i++) push_item({KW'(15 - i), VW'(15 - i)}, 1'b0);
        check("full_in_ready_drop", CW'(in_ready), CW'(0));
        check("full_busy", CW'(busy), CW'(1));
        wait_last(100);
        check("full_latency", CW'(first_ov_cyc - last_acc_cyc), CW'(L + 2));
        check("full_start_pulses", CW'(n_start), CW'(1));
        check_batch("full");
        check("full_in_ready_back", CW'(in_ready), CW'(1));

        // Partial batch closed by flush
        for (int i = 0; i < 5; i++) push_item({keys5[i], VW'(keys5[i] * 3)}, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) check("part_sort_in", CW'(sort_in_data[i]), CW'({1'b1, acc_q[i]}));
        for (int i = 5; i < NB; i++) check("part_pad_vld", CW'(sort_in_data[i][PW]), CW'(0));
        wait_last(100);
        check_batch("part");
        check("part_in_ready_back", CW'(in_ready), CW'(1));

        // Empty flush ignored, then flush together with the 3rd accept
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("empty_flush_busy", CW'(busy), CW'(0));
        check("empty_flush_in_ready", CW'(in_ready), CW'(1));
        push_item(rnd_item(2), 1'b0);
        push_item(rnd_item(0), 1'b0);
        push_item(rnd_item(1), 1'b1);
        check("flush3_busy", CW'(busy), CW'(1));
        wait_last(100);
        check_batch("flush3");

        // Backpressure 1-0-0-1 while draining a random full batch
        for (int i = 0; i < NB; i++) push_item(rnd_item(i), 1'b0);
        for (int t = 0; t < 300 && !last_seen; t++) begin
            out_ready = pat[t % 4][0];
            tick();
        end
        if (!last_seen) check("bp_timeout", CW'(last_seen), CW'(1));
        out_ready = 1'b1;
        check_batch("bp");

        // Reset while in WAIT
        for (int i = 0; i < 4; i++) push_item(rnd_item(i), i == 3);
        tick();
        reset_mid_cycle("rst_wait");

        // Reset in the middle of DRAIN
        out_ready = 1'b0;
        for (int i = 0; i < NB; i++) push_item(rnd_item(i), 1'b0);
        for (int t = 0; t < 40 && !out_valid; t++) tick();
        check("mid_drain_reached", CW'(out_valid), CW'(1));
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        reset_mid_cycle("rst_drain");

        // Back-to-back batches with in_valid held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rnd_item(0);
        for (int b = 0; b < 2; b++) begin
            for (int t = 0; t < 200 && !last_seen; t++) begin
                int sz;
                sz = acc_q.size();
                tick();
                if (acc_q.size() != sz) in_data = rnd_item(acc_q.size() % NB);
            end
            if (!last_seen) check("b2b_timeout", CW'(last_seen), CW'(1));
            check("b2b_accepts_at_last", CW'(acc_q.size()), CW'(NB));
            check_batch("b2b");
            in_data = rnd_item(0);
        end
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
